// File: rtl/conv_window_ctrl.sv
// Sliding-window controller: reads each KxK neighbourhood of an NxN map into a
// 25-entry window, registers the datapath result and writes it in raster order.
module conv_window_ctrl #(
    parameter int DW = 16,
    parameter int AW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          img_size,
    input  logic [15:0]          filter_size,
    input  logic [AW-1:0]        img_base,
    input  logic [AW-1:0]        out_base,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    input  logic signed [DW-1:0] rd_data,
    output logic signed [DW-1:0] win [0:24],
    input  logic signed [DW-1:0] conv_value,
    output logic                 wr_en,
    output logic [AW-1:0]        wr_addr,
    output logic signed [DW-1:0] wr_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_CONV, S_WRITE, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [15:0]          n_q, n_d, k_q, k_d;
    logic [AW-1:0]        ib_q, ib_d, ob_q, ob_d;
    logic [15:0]          r_q, r_d, c_q, c_d;
    logic [2:0]           i_q, i_d, j_q, j_d;
    logic                 cap_v_q, cap_v_d;
    logic [4:0]           cap_idx_q, cap_idx_d;
    logic signed [DW-1:0] win_q [0:24];
    logic signed [DW-1:0] win_d [0:24];
    logic signed [DW-1:0] conv_q, conv_d;
    logic                 err_q, err_d;
    logic                 legal;
    logic [15:0]          row, col;
    logic [31:0]          rd_off, wr_off;

    assign legal = (filter_size == 16'd3 || filter_size == 16'd5) && (img_size >= filter_size);

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        k_d       = k_q;
        ib_d      = ib_q;
        ob_d      = ob_q;
        r_d       = r_q;
        c_d       = c_q;
        i_d       = i_q;
        j_d       = j_q;
        cap_v_d   = 1'b0;
        cap_idx_d = cap_idx_q;
        conv_d    = conv_q;
        err_d     = 1'b0;
        win_d     = win_q;
        // read data lags its strobe by one cycle, so the tap index is carried along
        if (cap_v_q) begin
            win_d[cap_idx_q] = rd_data;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    n_d   = img_size;
                    k_d   = filter_size;
                    ib_d  = img_base;
                    ob_d  = out_base;
                    r_d   = '0;
                    c_d   = '0;
                    i_d   = '0;
                    j_d   = '0;
                    win_d = '{default: '0};
                    if (legal) begin
                        state_d = S_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                cap_v_d   = 1'b1;
                cap_idx_d = 5'(({13'd0, i_q} * k_q) + {13'd0, j_q});
                if ({13'd0, j_q} == k_q - 16'd1) begin
                    j_d = '0;
                    if ({13'd0, i_q} == k_q - 16'd1) begin
                        i_d     = '0;
                        state_d = S_WAIT;
                    end else begin
                        i_d = i_q + 3'd1;
                    end
                end else begin
                    j_d = j_q + 3'd1;
                end
            end
            S_WAIT:  state_d = S_CONV;
            S_CONV: begin
                conv_d  = conv_value;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                state_d = S_LOAD;
                if (c_q == n_q - k_q) begin
                    c_d = '0;
                    if (r_q == n_q - k_q) begin
                        state_d = S_DONE;
                    end else begin
                        r_d = r_q + 16'd1;
                    end
                end else begin
                    c_d = c_q + 16'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        row    = r_q + {13'd0, i_q};
        col    = c_q + {13'd0, j_q};
        rd_off = 32'(row) * 32'(n_q) + 32'(col);
        wr_off = 32'(r_q) * 32'(n_q - k_q + 16'd1) + 32'(c_q);
    end

    assign rd_en   = (state_q == S_LOAD);
    assign rd_addr = rd_en ? ib_q + AW'(rd_off) : '0;
    assign wr_en   = (state_q == S_WRITE);
    assign wr_addr = wr_en ? ob_q + AW'(wr_off) : '0;
    assign wr_data = conv_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign err     = err_q;
    assign win     = win_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            k_q       <= '0;
            ib_q      <= '0;
            ob_q      <= '0;
            r_q       <= '0;
            c_q       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            cap_v_q   <= 1'b0;
            cap_idx_q <= '0;
            conv_q    <= '0;
            err_q     <= 1'b0;
            win_q     <= '{default: '0};
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            k_q       <= k_d;
            ib_q      <= ib_d;
            ob_q      <= ob_d;
            r_q       <= r_d;
            c_q       <= c_d;
            i_q       <= i_d;
            j_q       <= j_d;
            cap_v_q   <= cap_v_d;
            cap_idx_q <= cap_idx_d;
            conv_q    <= conv_d;
            err_q     <= err_d;
            win_q     <= win_d;
        end
    end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: memory and summing datapath models, expected
// read/write sequences derived from nested-loop arithmetic over the image.
module tb_conv_window_ctrl;
    localparam int DW = 16;
    localparam int AW = 16;

    logic                 clk = 1'b0;
    logic                 rst, start;
    logic [15:0]          img_size, filter_size;
    logic [AW-1:0]        img_base, out_base;
    logic                 rd_en, wr_en, busy, done, err;
    logic [AW-1:0]        rd_addr, wr_addr;
    logic signed [DW-1:0] rd_data, conv_value, wr_data;
    logic signed [DW-1:0] win [0:24];

    conv_window_ctrl #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .img_size(img_size),
        .filter_size(filter_size), .img_base(img_base), .out_base(out_base),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .win(win),
        .conv_value(conv_value), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic signed [DW-1:0] mem [0:65535];
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : '0;

    logic signed [31:0] acc;
    always_comb begin
        acc = '0;
        for (int t = 0; t < 25; t++) acc = acc + 32'(win[t]);
        conv_value = acc[15:0];
    end

    logic [15:0] rd_log[$], wa_log[$], wd_log[$];
    logic [15:0] exp_rd[$], exp_wa[$], exp_wd[$];
    logic signed [DW-1:0] last_win [0:24];
    int err_cnt, busy_cnt;

    always @(negedge clk) begin
        if (rd_en) rd_log.push_back(rd_addr);
        if (wr_en) begin
            wa_log.push_back(wr_addr);
            wd_log.push_back(wr_data);
            last_win = win;
        end
        if (err)  err_cnt++;
        if (busy) busy_cnt++;
    end

    function automatic int seq_diff(input logic [15:0] a[$], input logic [15:0] b[$]);
        int d = (a.size() == b.size()) ? 0 : 1;
        for (int t = 0; t < a.size() && t < b.size(); t++) if (a[t] !== b[t]) d++;
        return d;
    endfunction

    task automatic model(input int n, input int k, input int ib, input int ob);
        exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
        for (int r = 0; r <= n - k; r++)
            for (int c = 0; c <= n - k; c++) begin
                int s = 0;
                for (int i = 0; i < k; i++)
                    for (int j = 0; j < k; j++) begin
                        logic [15:0] a = 16'(ib + (r + i) * n + c + j);
                        exp_rd.push_back(a);
                        s += int'(mem[a]);
                    end
                exp_wa.push_back(16'(ob + r * (n - k + 1) + c));
                exp_wd.push_back(16'(s));
            end
    endtask

    task automatic fill_random();
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
    endtask

    // ra/rb: cycles on which a conflicting start is pulsed; abort_at: cycle to assert rst
    task automatic run(input int n, input int k, input int ib, input int ob,
                       input int ra, input int rb, input int abort_at, output int cyc_done);
        bit aborted = 0;
        rd_log.delete(); wa_log.delete(); wd_log.delete();
        cyc_done = -1;
        @(negedge clk);
        img_size = 16'(n); filter_size = 16'(k);
        img_base = 16'(ib); out_base = 16'(ob); start = 1'b1;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(posedge clk); #1;
            start = (cyc == ra) || (cyc == rb);
            if (start) begin
                img_size = 16'd7; filter_size = 16'd5; img_base = 16'h1234; out_base = 16'h4321;
            end
            if (cyc == abort_at) begin
                #1 rst = 1'b1;
                aborted = 1;
                break;
            end
            @(negedge clk);
            if (done) begin
                cyc_done = cyc;
                break;
            end
        end
        if (!aborted) begin
            @(posedge clk); #1 start = 1'b0;
        end
    endtask

    task automatic test_reset();
        int nz = 0;
        rst = 1'b1; start = 1'b0;
        img_size = '0; filter_size = '0; img_base = '0; out_base = '0;
        repeat (3) @(negedge clk);
        for (int t = 0; t < 25; t++) if (win[t] !== '0) nz++;
        total++;
        if ({rd_en, wr_en, busy, done, err} !== 5'b0) $display("FAIL reset_ctrl: got %b expected 00000", {rd_en, wr_en, busy, done, err});
        else passed++;
        total++;
        if ({rd_addr, wr_addr, wr_data} !== 48'b0) $display("FAIL reset_data: got %h expected 0", {rd_addr, wr_addr, wr_data});
        else passed++;
        total++;
        if (nz !== 0) $display("FAIL reset_win: got %0d nonzero taps expected 0", nz);
        else passed++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_all_ones();
        int cyc, bad = 0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'sd1;
        model(5, 3, 100, 200);
        run(5, 3, 100, 200, 0, 0, 0, cyc);
        total++;
        if (cyc !== 109) $display("FAIL ones_done_latency: got %0d expected 109", cyc);
        else passed++;
        total++;
        if (wd_log.size() !== 9) $display("FAIL ones_write_count: got %0d expected 9", wd_log.size());
        else passed++;
        total++;
        if (seq_diff(wd_log, exp_wd) + seq_diff(wa_log, exp_wa) !== 0)
            $display("FAIL ones_writes: got %0d differing entries expected 0", seq_diff(wd_log, exp_wd) + seq_diff(wa_log, exp_wa));
        else passed++;
        for (int t = 9; t < 25; t++) if (last_win[t] !== '0) bad++;
        total++;
        if (bad !== 0) $display("FAIL ones_unused_taps: got %0d nonzero expected 0", bad);
        else passed++;
    endtask

    task automatic test_full_5x5();
        int cyc, bad = 0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'(a);
        model(5, 5, 0, 50);
        run(5, 5, 0, 50, 0, 0, 0, cyc);
        total++;
        if (rd_log.size() !== 25) $display("FAIL k5_reads: got %0d expected 25", rd_log.size());
        else passed++;
        for (int t = 0; t < 25; t++) if (last_win[t] !== 16'(t)) bad++;
        total++;
        if (bad !== 0) $display("FAIL k5_window: got %0d wrong taps expected 0", bad);
        else passed++;
        total++;
        if (wd_log.size() !== 1 || wd_log[0] !== 16'd300 || wa_log[0] !== 16'd50)
            $display("FAIL k5_write: got %0d writes data %0d expected 1 write data 300", wd_log.size(), wd_log.size() ? wd_log[0] : 0);
        else passed++;
        total++;
        if (cyc !== 29) $display("FAIL k5_latency: got %0d expected 29", cyc);
        else passed++;
    endtask

    task automatic test_illegal();
        int cfg_n[2] = '{8, 2};
        int cfg_k[2] = '{4, 3};
        rd_log.delete(); wa_log.delete();
        err_cnt = 0; busy_cnt = 0;
        for (int p = 0; p < 2; p++) begin
            @(negedge clk);
            img_size = 16'(cfg_n[p]); filter_size = 16'(cfg_k[p]); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            total++;
            if (err !== 1'b1) $display("FAIL illegal_err_pulse: got %b expected 1 (cfg %0d)", err, p);
            else passed++;
            repeat (5) @(negedge clk);
        end
        total++;
        if (err_cnt !== 2) $display("FAIL illegal_err_count: got %0d expected 2", err_cnt);
        else passed++;
        total++;
        if (rd_log.size() + wa_log.size() + busy_cnt !== 0)
            $display("FAIL illegal_activity: got %0d reads %0d writes %0d busy expected 0", rd_log.size(), wa_log.size(), busy_cnt);
        else passed++;
    endtask

    task automatic test_start_while_busy();
        int cyc, nr, nw;
        fill_random();
        model(5, 3, 16'h0300, 16'h0900);
        run(5, 3, 16'h0300, 16'h0900, 30, 109, 0, cyc);
        total++;
        if (cyc !== 109) $display("FAIL busy_latency: got %0d expected 109", cyc);
        else passed++;
        total++;
        if (wa_log.size() !== 9) $display("FAIL busy_write_count: got %0d expected 9", wa_log.size());
        else passed++;
        total++;
        if (seq_diff(rd_log, exp_rd) + seq_diff(wa_log, exp_wa) + seq_diff(wd_log, exp_wd) !== 0)
            $display("FAIL busy_sequence: got %0d differing entries expected 0",
                     seq_diff(rd_log, exp_rd) + seq_diff(wa_log, exp_wa) + seq_diff(wd_log, exp_wd));
        else passed++;
        nr = rd_log.size(); nw = wa_log.size();
        repeat (20) @(negedge clk);
        total++;
        if (busy !== 1'b0 || rd_log.size() !== nr || wa_log.size() !== nw)
            $display("FAIL busy_after_done: got busy %b reads %0d expected busy 0 reads %0d", busy, rd_log.size(), nr);
        else passed++;
    endtask

    task automatic test_reset_mid_run();
        int cyc, nz = 0;
        fill_random();
        model(5, 3, 16'h0040, 16'h0A00);
        run(5, 3, 16'h0040, 16'h0A00, 0, 0, 27, cyc);
        #1;
        for (int t = 0; t < 25; t++) if (win[t] !== '0) nz++;
        total++;
        if ({rd_en, wr_en, busy, done, err} !== 5'b0 || {rd_addr, wr_addr, wr_data} !== 48'b0 || nz !== 0)
            $display("FAIL abort_outputs: got ctrl %b data %h win_nz %0d expected all 0",
                     {rd_en, wr_en, busy, done, err}, {rd_addr, wr_addr, wr_data}, nz);
        else passed++;
        total++;
        if (wa_log.size() !== 2) $display("FAIL abort_partial_writes: got %0d expected 2", wa_log.size());
        else passed++;
        @(negedge clk);
        rst = 1'b0;
        run(5, 3, 16'h0040, 16'h0A00, 0, 0, 0, cyc);
        total++;
        if (cyc !== 109 || seq_diff(rd_log, exp_rd) + seq_diff(wa_log, exp_wa) + seq_diff(wd_log, exp_wd) !== 0)
            $display("FAIL abort_rerun: got latency %0d diffs %0d expected 109 and 0", cyc,
                     seq_diff(rd_log, exp_rd) + seq_diff(wa_log, exp_wa) + seq_diff(wd_log, exp_wd));
        else passed++;
    endtask

    task automatic test_addr_wrap();
        int cyc;
        fill_random();
        model(5, 3, 16'hFFFE, 16'h0100);
        run(5, 3, 16'hFFFE, 16'h0100, 0, 0, 0, cyc);
        total++;
        if (rd_log.size() < 3 || rd_log[0] !== 16'hFFFE || rd_log[2] !== 16'h0000)
            $display("FAIL wrap_first_reads: got %h %h expected fffe 0000",
                     rd_log.size() > 0 ? rd_log[0] : 16'h0, rd_log.size() > 2 ? rd_log[2] : 16'h0);
        else passed++;
        total++;
        if (seq_diff(rd_log, exp_rd) + seq_diff(wd_log, exp_wd) !== 0)
            $display("FAIL wrap_sequence: got %0d differing entries expected 0", seq_diff(rd_log, exp_rd) + seq_diff(wd_log, exp_wd));
        else passed++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int n, k, ib, ob, cyc, d;
            n  = $urandom_range(3, 8);
            k  = (n >= 5 && $urandom_range(0, 1) == 1) ? 5 : 3;
            ib = $urandom_range(0, 65535);
            ob = $urandom_range(0, 65535);
            fill_random();
            model(n, k, ib, ob);
            run(n, k, ib, ob, 0, 0, 0, cyc);
            d = seq_diff(rd_log, exp_rd) + seq_diff(wa_log, exp_wa) + seq_diff(wd_log, exp_wd);
            total++;
            if (d !== 0) $display("FAIL random_seq_%0d: got %0d differing entries expected 0 (N=%0d K=%0d)", it, d, n, k);
            else passed++;
            total++;
            if (cyc !== (n - k + 1) * (n - k + 1) * (k * k + 3) + 1)
                $display("FAIL random_latency_%0d: got %0d expected %0d", it, cyc, (n - k + 1) * (n - k + 1) * (k * k + 3) + 1);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_full_5x5();
        test_illegal();
        test_start_while_busy();
        test_reset_mid_run();
        test_addr_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 SHALL have parameter DW, default 16, meaning data width.
REQ-002 SHALL have parameter AW, default 16, meaning memory address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, request to convolve one feature map.
REQ-006 SHALL have port img_size, input, 16, input map side N (square).
REQ-007 SHALL have port filter_size, input, 16, filter side K; only 3 or 5 are legal.
REQ-008 SHALL have port img_base, input, AW, base read address of input map.
REQ-009 SHALL have port out_base, input, AW, base write address of output map.
REQ-010 SHALL have port rd_en, output, 1, memory read strobe.
REQ-011 SHALL have port rd_addr, output, AW, memory read address.
REQ-012 SHALL have port rd_data, input, DW signed, read data, valid exactly 1 cycle after rd_en.
REQ-013 SHALL have port win, output, 25 x DW signed, window to convolution datapath.
REQ-014 SHALL have port conv_value, input, DW signed, combinational datapath result for win.
REQ-015 SHALL have port wr_en, output, 1, output write strobe.
REQ-016 SHALL have port wr_addr, output, AW, output write address.
REQ-017 SHALL have port wr_data, output, DW signed, output pixel.
REQ-018 SHALL have port busy, output, 1, high in every non-IDLE state.
REQ-019 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-020 SHALL have port err, output, 1, one-cycle illegal-config pulse.

Function
REQ-021 SHALL implement FSM states IDLE, LOAD, WAIT, CONV, WRITE, DONE.
REQ-022 SHALL accept start only in IDLE: latch img_size, filter_size, img_base, out_base; clear window; r=c=0.
REQ-023 SHALL ignore start in any state other than IDLE; latched parameters are not changed.
REQ-024 SHALL, on accept with K not in {3,5} or N<K, pulse err next cycle, stay IDLE, issue no reads or writes.
REQ-025 SHALL, in LOAD, assert rd_en for exactly K*K consecutive cycles, row-major i,j in 0..K-1, rd_addr = img_base + (r+i)*N + (c+j), all sums truncated to AW bits.
REQ-026 SHALL store the rd_data returned for tap (i,j) into win[i*K+j]; win[K*K..24] SHALL stay 0.
REQ-027 SHALL spend 1 cycle in WAIT to capture the last tap, then 1 cycle in CONV registering conv_value.
REQ-028 SHALL, in WRITE, assert wr_en for 1 cycle with wr_addr = out_base + r*(N-K+1) + c and wr_data = the registered value.
REQ-029 SHALL, after WRITE, increment c; when c = N-K, wrap c to 0 and increment r; when r = N-K also, go to DONE, else go to LOAD.
REQ-030 SHALL take exactly K*K+3 cycles per output pixel, and produce (N-K+1)^2 writes in raster order.
REQ-031 SHALL pulse done for 1 cycle in DONE, then return to IDLE; start on that cycle SHALL be ignored.
REQ-032 SHALL hold rd_en, wr_en, done and err at 0 outside the states named above.
REQ-033 SHALL hold win stable from WAIT exit through WRITE.

Reset
REQ-034 SHALL, on rst high at any time, enter IDLE immediately, aborting any pending write.
REQ-035 SHALL reset all outputs to 0, including all win entries, rd_addr, wr_addr, wr_data, busy, done and err.
REQ-036 SHALL set r, c and the tap counter to 0 on reset.
REQ-037 SHALL resume normal operation on the first clock edge after rst deasserts.

Verification
REQ-038 SHALL cover: N=5, K=3, all-ones image, datapath model = sum of win -> 9 writes of value 9 at out_base+0..8; done 109 cycles after start.
REQ-039 SHALL cover: N=5, K=5, image value = address, img_base=0 -> 1 write; win[0..24] = 0..24; exactly 25 reads.
REQ-040 SHALL cover: K=4, then N=2 with K=3 -> err pulses once each; rd_en and wr_en stay 0; busy stays 0.
REQ-041 SHALL cover: start re-asserted while busy with N=5, K=3 -> ignored; write count stays 9; address sequence unchanged.
REQ-042 SHALL cover: rst asserted during the 3rd LOAD of a run -> all outputs 0 asynchronously; a new start then gives the full 9-write sequence.
REQ-043 SHALL cover: img_base=16'hFFFE, N=5, K=3 -> rd_addr wraps modulo 2^16; first read at FFFE, 3rd read at 0000.
